pwm_motor_drive: RTL and testbench
==================================

Name: pwm_motor_drive

Overview:
Parametrised multi-channel H-bridge PWM generator, the successor to the two-output single-motor PWM block. One shared prescaled period counter drives CH independent channels. Each channel adds duty-cycle slew limiting (soft start/stop), brake/coast modes, and a safe direction-reversal sequence with dead time. It sits between the command decoder (Bluetooth / line-follow / obstacle logic) and the motor driver pins.

Parameters:
CH, 2, number of motor channels
W, 8, speed/duty width; PWM period = MAXV = 2^W-1 ticks
PRESCALE, 1, CLK cycles per PWM tick (>=1)
RAMP_STEP, 8, maximum duty change per PWM period (1..MAXV)
DEAD_PERIODS, 4, full PWM periods with both outputs low during reversal (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous active-low reset
speed  in  CH*W  target duty per channel; channel k = speed[k*W +: W]
dir_in  in  CH*2  per-channel command: 00 coast, 01 forward, 10 reverse, 11 brake
pwm1  in/out: output  CH  bridge input A per channel
pwm2  output  CH  bridge input B per channel
cur_duty  output  CH*W  present applied duty per channel
busy  output  CH  channel in DECEL or DEAD (reversal in progress)

Behaviour:
- Reset (RST_N=0 at a CLK edge): prescaler=0, cnt=0, every channel IDLE, cur=0, pwm1=pwm2=0, busy=0. Applies mid-operation with no exceptions.
- Tick: asserted for one CLK when the prescaler reaches PRESCALE-1, after which the prescaler returns to 0. With PRESCALE=1, tick is asserted every cycle.
- cnt: advances on each tick from 0 to MAXV-1, then returns to 0. wrap = tick && cnt==MAXV-1.
- Duty compare: on = (cnt < cur). cur=0 gives always off. cur=MAXV gives always on.
- Outputs: registered, so they lag cnt/cur/state by 1 CLK.
  - FWD: pwm1=on, pwm2=0.
  - REV: pwm1=0, pwm2=on.
  - IDLE and DEAD: both 0.
  - BRAKE: both 1.
  - DECEL: active direction of the previous state, modulated by on.
- Ramp: applied only on wrap, in FWD, REV and DECEL. Target is speed in FWD/REV and 0 in DECEL.
  - If cur < target: cur = min(cur+RAMP_STEP, target).
  - If cur > target: cur = max(cur-RAMP_STEP, target).
  - Arithmetic is W+1 bits, with no wrap-around.
  - A speed change mid-period takes effect at the next wrap.
- Per-channel FSM; dir_in is sampled every CLK:
  - IDLE:
    - 01 -> FWD with cur=0.
    - 10 -> REV with cur=0.
    - 11 -> BRAKE.
  - FWD/REV:
    - Same direction: stay.
    - Opposite direction -> DECEL, busy=1.
    - 00 -> IDLE, cur=0 immediately.
    - 11 -> BRAKE, cur=0 immediately.
  - DECEL:
    - Ramps toward 0. When cur==0 at a wrap -> DEAD, with dead counter = 0.
    - 00 -> IDLE and 11 -> BRAKE still override immediately.
    - A return to the original direction -> back to FWD/REV, continuing the ramp from the present cur.
  - DEAD:
    - Counts wraps. After DEAD_PERIODS wraps, enters the direction given by dir_in at that cycle (01/10) with cur=0. If dir_in is 00 it enters IDLE; if 11, BRAKE.
    - dir_in is otherwise ignored during DEAD.
  - BRAKE:
    - 00 -> IDLE.
    - 01/10 -> FWD/REV with cur=0. No dead time is needed, since the motor is stopped.
- busy = state in {DECEL, DEAD}.
- cur_duty = cur.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Test Plan:
Parameters for all scenarios: CH=2, W=4 (MAXV=15), PRESCALE=1, RAMP_STEP=4, DEAD_PERIODS=2.
- Reset: hold RST_N=0 for 3 CLK with dir_in=01, speed=15 -> pwm1=pwm2=0, cur_duty=0, busy=0. After release, channel 0 enters FWD.
- Soft start: ch0 dir=01, speed=10 -> cur_duty sequence 4, 8, 10 at successive wraps (15 CLK apart). In steady state pwm1 is high 10 of every 15 CLK and pwm2 stays 0.
- Full/zero duty: speed=15 -> after ramp, pwm1 is constantly 1. speed=0 -> ramps 15, 11, 7, 3, 0, then pwm1 is constantly 0.
- Reversal: at steady cur=10 (FWD), set dir=10 -> busy=1; cur goes 6, 2, 0; then 2 periods with both outputs low; then REV with pwm2 ramping 4, 8, 10 and busy=0.
- Overrides: during DECEL set dir=11 -> next CLK+1 pwm1=pwm2=1 and cur=0. Then dir=00 -> both outputs 0.
- Independence/prescale: with PRESCALE=3, ch0 FWD speed 5 and ch1 REV speed 12 -> period is 45 CLK. pwm1[0] is high 15 CLK per period; pwm2[1] is high 36 CLK per period.

Source files
------------

// File: rtl/pwm_motor_drive_if.sv
// Command/status bundle between the motion decoder and the multi-channel PWM bridge driver.
// Channel k owns speed[k*W +: W], dir_in[k*2 +: 2] and bit k of every per-channel output.
interface pwm_motor_drive_if #(
    parameter int CH = 2,
    parameter int W  = 8
);
    logic [CH*W-1:0] speed;
    logic [CH*2-1:0] dir_in;
    logic [CH-1:0]   pwm1;
    logic [CH-1:0]   pwm2;
    logic [CH*W-1:0] cur_duty;
    logic [CH-1:0]   busy;

    modport master (output speed, dir_in, input pwm1, pwm2, cur_duty, busy);
    modport slave  (input speed, dir_in, output pwm1, pwm2, cur_duty, busy);
endinterface

// File: rtl/pwm_motor_drive.sv
// Multi-channel H-bridge PWM: a shared prescaled period counter and per-channel slew-limited duty,
// brake/coast modes and a reversal sequence that holds both bridge inputs low for dead time.
module pwm_motor_ch #(
    parameter int W            = 8,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_cnt,
    input  logic         i_wrap,
    input  logic [W-1:0] i_speed,
    input  logic [1:0]   i_dir,
    output logic         o_pwm1,
    output logic         o_pwm2,
    output logic [W-1:0] o_cur,
    output logic         o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_FWD, S_REV, S_DECEL, S_DEAD, S_BRAKE} state_t;

    localparam logic [1:0] D_COAST = 2'b00;
    localparam logic [1:0] D_FWD   = 2'b01;
    localparam logic [1:0] D_REV   = 2'b10;
    localparam logic [1:0] D_BRAKE = 2'b11;
    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    state_t        r_state;
    logic [W-1:0]  r_cur;
    logic          r_fwd;
    logic [DW-1:0] r_dead;
    logic          r_pwm1;
    logic          r_pwm2;

    logic          w_on;
    logic [W-1:0]  w_tgt;
    logic [W-1:0]  w_ramp;
    logic [W:0]    w_up;
    logic [W:0]    w_dn_lim;

    assign w_on     = (i_cnt < r_cur);
    assign w_tgt    = (r_state == S_DECEL) ? '0 : i_speed;
    assign w_up     = {1'b0, r_cur} + (W+1)'(RAMP_STEP);
    assign w_dn_lim = {1'b0, w_tgt} + (W+1)'(RAMP_STEP);

    // One extra bit keeps the step from wrapping past either rail before clamping to target.
    always_comb begin
        w_ramp = r_cur;
        if (r_cur < w_tgt)
            w_ramp = (w_up > {1'b0, w_tgt}) ? w_tgt : w_up[W-1:0];
        else if (r_cur > w_tgt)
            w_ramp = ({1'b0, r_cur} > w_dn_lim) ? (r_cur - W'(RAMP_STEP)) : w_tgt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_fwd   <= 1'b1;
            r_dead  <= '0;
            r_pwm1  <= 1'b0;
            r_pwm2  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_BRAKE: begin
                    case (i_dir)
                        D_FWD:   begin r_state <= S_FWD; r_fwd <= 1'b1; r_cur <= '0; end
                        D_REV:   begin r_state <= S_REV; r_fwd <= 1'b0; r_cur <= '0; end
                        D_BRAKE: r_state <= S_BRAKE;
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_FWD, S_REV: begin
                    if (i_dir == D_COAST) begin
                        r_state <= S_IDLE;
                        r_cur   <= '0;
                    end else if (i_dir == D_BRAKE) begin
                        r_state <= S_BRAKE;
                        r_cur   <= '0;
                    end else if ((i_dir == D_FWD) != r_fwd) begin
                        r_state <= S_DECEL;
                    end else if (i_wrap) begin
                        r_cur <= w_ramp;
                    end
                end
                S_DECEL: begin
                    if (i_dir == D_COAST) begin
                        r_state <= S_IDLE;
                        r_cur   <= '0;
                    end else if (i_dir == D_BRAKE) begin
                        r_state <= S_BRAKE;
                        r_cur   <= '0;
                    end else if ((i_dir == D_FWD) == r_fwd) begin
                        r_state <= r_fwd ? S_FWD : S_REV;
                    end else if (i_wrap) begin
                        if (r_cur == '0) begin
                            r_state <= S_DEAD;
                            r_dead  <= '0;
                        end else begin
                            r_cur <= w_ramp;
                        end
                    end
                end
                S_DEAD: begin
                    // Command is only looked at on the wrap that ends the dead time.
                    if (i_wrap) begin
                        if (r_dead == DW'(DEAD_PERIODS-1)) begin
                            r_cur  <= '0;
                            r_dead <= '0;
                            case (i_dir)
                                D_FWD:   begin r_state <= S_FWD; r_fwd <= 1'b1; end
                                D_REV:   begin r_state <= S_REV; r_fwd <= 1'b0; end
                                D_BRAKE: r_state <= S_BRAKE;
                                default: r_state <= S_IDLE;
                            endcase
                        end else begin
                            r_dead <= r_dead + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
            case (r_state)
                S_FWD:   r_pwm1 <= w_on;
                S_REV:   r_pwm2 <= w_on;
                S_DECEL: if (r_fwd) r_pwm1 <= w_on; else r_pwm2 <= w_on;
                S_BRAKE: begin r_pwm1 <= 1'b1; r_pwm2 <= 1'b1; end
                default: ;
            endcase
        end
    end

    assign o_pwm1 = r_pwm1;
    assign o_pwm2 = r_pwm2;
    assign o_cur  = r_cur;
    assign o_busy = (r_state == S_DECEL) || (r_state == S_DEAD);
endmodule

module pwm_motor_drive #(
    parameter int CH           = 2,
    parameter int W            = 8,
    parameter int PRESCALE     = 1,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    pwm_motor_drive_if.slave  bus
);
    localparam int MAXV = (1 << W) - 1;
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]   r_pre;
    logic [W-1:0]    r_cnt;
    logic            w_tick;
    logic            w_wrap;
    logic [CH-1:0]   w_pwm1;
    logic [CH-1:0]   w_pwm2;
    logic [CH-1:0]   w_busy;
    logic [CH*W-1:0] w_cur;

    assign w_tick = (r_pre == PW'(PRESCALE-1));
    assign w_wrap = w_tick && (r_cnt == W'(MAXV-1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pwm_motor_ch #(
            .W            (W),
            .RAMP_STEP    (RAMP_STEP),
            .DEAD_PERIODS (DEAD_PERIODS)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst_n (RST_N),
            .i_cnt   (r_cnt),
            .i_wrap  (w_wrap),
            .i_speed (bus.speed[k*W +: W]),
            .i_dir   (bus.dir_in[k*2 +: 2]),
            .o_pwm1  (w_pwm1[k]),
            .o_pwm2  (w_pwm2[k]),
            .o_cur   (w_cur[k*W +: W]),
            .o_busy  (w_busy[k])
        );
    end

    assign bus.pwm1     = w_pwm1;
    assign bus.pwm2     = w_pwm2;
    assign bus.cur_duty = w_cur;
    assign bus.busy     = w_busy;
endmodule

// File: tb/tb_pwm_motor_drive.sv
// Scoreboarded bench: expected channel-0 duty steps are queued as commands are issued and
// compared whenever the applied duty changes; waveform-level properties are checked directly.
module tb_pwm_motor_drive;
    localparam int CH = 2;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_motor_drive_if #(.CH(CH), .W(W)) bus_a();
    pwm_motor_drive_if #(.CH(CH), .W(W)) bus_b();

    pwm_motor_drive #(.CH(CH), .W(W), .PRESCALE(1), .RAMP_STEP(4), .DEAD_PERIODS(2)) u_dut_a (
        .CLK(clk), .RST_N(rst_a), .bus(bus_a)
    );
    pwm_motor_drive #(.CH(CH), .W(W), .PRESCALE(3), .RAMP_STEP(4), .DEAD_PERIODS(2)) u_dut_b (
        .CLK(clk), .RST_N(rst_b), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int         q_exp[$];
    int         q_stamp[$];
    logic [W-1:0] prev_a = '0;

    always @(negedge clk) begin
        if (rst_a === 1'b1 && bus_a.cur_duty[W-1:0] !== prev_a) begin
            if (q_exp.size() > 0) begin
                chk("sb_cur", 32'(bus_a.cur_duty[W-1:0]), 32'(q_exp.pop_front()));
                q_stamp.push_back(cyc);
            end else begin
                chk("sb_unexpected_change", 32'(bus_a.cur_duty[W-1:0]), 32'(prev_a));
            end
        end
        prev_a <= bus_a.cur_duty[W-1:0];
    end

    task automatic drain(input string tag, input int budget, input int left);
        int i = 0;
        while (q_exp.size() > left && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk(tag, 32'(q_exp.size()), 32'(left));
    endtask

    // Counts high samples of one selected output over n consecutive cycles.
    task automatic cnt_hi(input int sel, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            case (sel)
                0: c += int'(bus_a.pwm1[0]);
                1: c += int'(bus_a.pwm2[0]);
                2: c += int'(bus_a.pwm1[0] | bus_a.pwm2[0]);
                3: c += int'(bus_b.pwm1[0]);
                4: c += int'(bus_b.pwm2[1]);
                5: c += int'(bus_b.pwm2[0]);
                default: c += int'(bus_b.pwm1[1]);
            endcase
        end
    endtask

    task automatic period_b(output int p);
        logic prv;
        bit   found = 0;
        p = 0;
        prv = bus_b.pwm1[0];
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus_b.pwm1[0] && !prv) found = 1;
            prv = bus_b.pwm1[0];
        end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            p++;
            if (bus_b.pwm1[0] && !prv) found = 1;
            prv = bus_b.pwm1[0];
        end
    endtask

    initial begin
        int c;
        int rel;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.speed  = {4'd0, 4'd15};
        bus_a.dir_in = {2'b00, 2'b01};
        bus_b.speed  = {4'd12, 4'd5};
        bus_b.dir_in = {2'b10, 2'b01};

        repeat (3) @(negedge clk);
        chk("rst_pwm1", 32'(bus_a.pwm1), 0);
        chk("rst_pwm2", 32'(bus_a.pwm2), 0);
        chk("rst_cur", 32'(bus_a.cur_duty), 0);
        chk("rst_busy", 32'(bus_a.busy), 0);

        // Release into FWD at full speed: first step lands one full period later.
        q_exp = '{4, 8, 12, 15};
        q_stamp.delete();
        rst_a = 1'b1;
        rel = cyc;
        drain("drain_full", 120, 0);
        chk("first_wrap_latency", 32'((q_stamp.size() > 0) ? q_stamp[0] - rel : -1), 15);
        cnt_hi(0, 15, c); chk("full_pwm1_hi", 32'(c), 15);
        cnt_hi(1, 15, c); chk("full_pwm2_hi", 32'(c), 0);

        bus_a.speed[3:0] = 4'd0;
        q_exp = '{11, 7, 3, 0};
        drain("drain_zero", 120, 0);
        cnt_hi(0, 15, c); chk("zero_pwm1_hi", 32'(c), 0);

        bus_a.speed[3:0] = 4'd10;
        q_exp = '{4, 8, 10};
        q_stamp.delete();
        drain("drain_soft", 100, 0);
        chk("soft_gap1", 32'((q_stamp.size() > 2) ? q_stamp[1] - q_stamp[0] : -1), 15);
        chk("soft_gap2", 32'((q_stamp.size() > 2) ? q_stamp[2] - q_stamp[1] : -1), 15);
        cnt_hi(0, 15, c); chk("soft_pwm1_hi", 32'(c), 10);
        cnt_hi(1, 15, c); chk("soft_pwm2_hi", 32'(c), 0);

        // Reversal: decel 6,2,0, dead time, then reverse ramp.
        bus_a.dir_in[1:0] = 2'b10;
        q_exp = '{6, 2, 0, 4, 8, 10};
        q_stamp.delete();
        @(negedge clk);
        chk("rev_busy_start", 32'(bus_a.busy[0]), 1);
        drain("drain_decel", 80, 3);
        chk("rev_busy_zero", 32'(bus_a.busy[0]), 1);
        cnt_hi(2, 40, c); chk("rev_dead_outputs_hi", 32'(c), 0);
        chk("rev_busy_dead", 32'(bus_a.busy[0]), 1);
        drain("drain_rev", 120, 0);
        chk("rev_zero_to_4_gap", 32'((q_stamp.size() > 3) ? q_stamp[3] - q_stamp[2] : -1), 60);
        chk("rev_busy_done", 32'(bus_a.busy[0]), 0);
        cnt_hi(1, 15, c); chk("rev_pwm2_hi", 32'(c), 10);
        cnt_hi(0, 15, c); chk("rev_pwm1_hi", 32'(c), 0);

        // Brake and coast override an in-progress deceleration.
        bus_a.dir_in[1:0] = 2'b01;
        q_exp = '{6};
        drain("drain_ovr_decel", 40, 0);
        chk("ovr_busy_decel", 32'(bus_a.busy[0]), 1);
        q_exp = '{0};
        bus_a.dir_in[1:0] = 2'b11;
        @(negedge clk);
        chk("ovr_brake_cur", 32'(bus_a.cur_duty[3:0]), 0);
        @(negedge clk);
        chk("ovr_brake_pwm1", 32'(bus_a.pwm1[0]), 1);
        chk("ovr_brake_pwm2", 32'(bus_a.pwm2[0]), 1);
        chk("ovr_brake_busy", 32'(bus_a.busy[0]), 0);
        bus_a.dir_in[1:0] = 2'b00;
        repeat (2) @(negedge clk);
        chk("ovr_coast_pwm", 32'({bus_a.pwm1[0], bus_a.pwm2[0]}), 0);
        chk("ovr_sb_empty", 32'(q_exp.size()), 0);

        // Mid-operation reset, and channel 1 untouched throughout.
        bus_a.speed[3:0] = 4'd15;
        bus_a.dir_in[1:0] = 2'b01;
        q_exp = '{4};
        drain("drain_pre_rst", 40, 0);
        chk("ch1_idle_cur", 32'(bus_a.cur_duty[7:4]), 0);
        chk("ch1_idle_pwm", 32'({bus_a.pwm1[1], bus_a.pwm2[1]}), 0);
        rst_a = 1'b0;
        @(negedge clk);
        chk("midrst_cur", 32'(bus_a.cur_duty), 0);
        chk("midrst_pwm1", 32'(bus_a.pwm1), 0);
        chk("midrst_busy", 32'(bus_a.busy), 0);

        // Prescaled instance: two channels in opposite directions, 45-cycle period.
        rst_b = 1'b1;
        repeat (200) @(negedge clk);
        chk("ps_cur0", 32'(bus_b.cur_duty[3:0]), 5);
        chk("ps_cur1", 32'(bus_b.cur_duty[7:4]), 12);
        cnt_hi(3, 45, c); chk("ps_pwm1_0_hi", 32'(c), 15);
        cnt_hi(4, 45, c); chk("ps_pwm2_1_hi", 32'(c), 36);
        cnt_hi(5, 45, c); chk("ps_pwm2_0_hi", 32'(c), 0);
        cnt_hi(6, 45, c); chk("ps_pwm1_1_hi", 32'(c), 0);
        period_b(c); chk("ps_period", 32'(c), 45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
